// File: rtl/imm_field_decode.sv
// rtl/imm_field_decode.sv - RV32I immediate field slicer with 2-entry skid buffer.
// Optional U/J immediate support is enabled by defining IMM_DECODE_UJ_EN.
module imm_field_decode #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [4:0]      iimm_shamt,
  output logic [11:0]     iimm,
  output logic [11:0]     simm,
  output logic [11:0]     bimm,
  output logic [19:0]     uimm,
  output logic [19:0]     jimm,
  output logic [2:0]      ext_op,
  output logic            illegal
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      shamt;
    logic [11:0]     iimm;
    logic [11:0]     simm;
    logic [11:0]     bimm;
    logic [19:0]     uimm;
    logic [19:0]     jimm;
    logic [2:0]      ext_op;
    logic            illegal;
  } word_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state;
  word_t  dec;
  word_t  entry0;
  word_t  entry1;
  logic   out_valid_q;
  logic   in_ready_q;
  logic   accept;
  logic   deliver;

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.instr   = in_instr;
    dec.shamt   = in_instr[24:20];
    dec.iimm    = in_instr[31:20];
    dec.simm    = {in_instr[31:25], in_instr[11:7]};
    dec.bimm    = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};
`ifdef IMM_DECODE_UJ_EN
    dec.uimm    = in_instr[31:12];
    dec.jimm    = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]};
`endif
    case (in_instr[6:0])
      7'b0010011: dec.ext_op = (in_instr[13:12] == 2'b01) ? 3'b011 : 3'b010;
      7'b0000011,
      7'b1100111: dec.ext_op = 3'b010;
      7'b0100011: dec.ext_op = 3'b001;
      7'b1100011: dec.ext_op = 3'b100;
`ifdef IMM_DECODE_UJ_EN
      7'b0110111,
      7'b0010111: dec.ext_op = 3'b101;
      7'b1101111: dec.ext_op = 3'b110;
`else
      // Extender without U/J support decodes 000 to an immediate of 0.
      7'b0110111,
      7'b0010111,
      7'b1101111: dec.ext_op = 3'b000;
`endif
      7'b0110011,
      7'b0001111,
      7'b1110011: dec.ext_op = 3'b000;
      default:    dec.illegal = 1'b1;
    endcase
  end

  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      entry0      <= '0;
      entry1      <= '0;
    end else if (flush) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            entry0      <= dec;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            entry0 <= dec;
          end else if (accept) begin
            entry1     <= dec;
            state      <= TWO;
            in_ready_q <= 1'b0;
          end else if (deliver) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (deliver) begin
            entry0     <= entry1;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_pc     = entry0.pc;
  assign out_instr  = entry0.instr;
  assign iimm_shamt = entry0.shamt;
  assign iimm       = entry0.iimm;
  assign simm       = entry0.simm;
  assign bimm       = entry0.bimm;
  assign uimm       = entry0.uimm;
  assign jimm       = entry0.jimm;
  assign ext_op     = entry0.ext_op;
  assign illegal    = entry0.illegal;

endmodule

// File: tb/tb_imm_field_decode.sv
// tb/tb_imm_field_decode.sv - directed and random checks of imm_field_decode against a queue model.
module tb_imm_field_decode;

`ifdef IMM_DECODE_UJ_EN
  localparam bit UJ = 1'b1;
`else
  localparam bit UJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  iimm_shamt;
  logic [11:0] iimm;
  logic [11:0] simm;
  logic [11:0] bimm;
  logic [19:0] uimm;
  logic [19:0] jimm;
  logic [2:0]  ext_op;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_instr[$];
  logic [31:0] q_pc[$];
  logic [31:0] pc_ctr = 32'h1000;

  imm_field_decode #(.PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .iimm_shamt(iimm_shamt), .iimm(iimm), .simm(simm), .bimm(bimm),
    .uimm(uimm), .jimm(jimm), .ext_op(ext_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference rules: RISC-V immediate layouts and the extender opcode table.
  function automatic logic [2:0] ref_ext(input logic [31:0] w);
    int op = int'(w[6:0]);
    int f3 = int'(w[14:12]);
    if (op == 'h13) return (f3 == 1 || f3 == 5) ? 3'd3 : 3'd2;
    if (op == 'h03 || op == 'h67) return 3'd2;
    if (op == 'h23) return 3'd1;
    if (op == 'h63) return 3'd4;
    if (op == 'h37 || op == 'h17) return UJ ? 3'd5 : 3'd0;
    if (op == 'h6F) return UJ ? 3'd6 : 3'd0;
    return 3'd0;
  endfunction

  function automatic logic ref_illegal(input logic [31:0] w);
    int op = int'(w[6:0]);
    return !(op == 'h13 || op == 'h03 || op == 'h67 || op == 'h23 || op == 'h63 ||
             op == 'h37 || op == 'h17 || op == 'h6F || op == 'h33 || op == 'h0F || op == 'h73);
  endfunction

  function automatic logic [31:0] ref_bimm(input logic [31:0] w);
    int v = 0;
    v += int'(w[11:8]);
    v += int'(w[30:25]) * 16;
    v += int'(w[7]) * 1024;
    v += int'(w[31]) * 2048;
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_jimm(input logic [31:0] w);
    int v = 0;
    if (!UJ) return 0;
    v += int'(w[30:21]);
    v += int'(w[20]) * 1024;
    v += int'(w[19:12]) * 2048;
    v += int'(w[31]) * 524288;
    return 32'(v);
  endfunction

  task automatic compare_all();
    logic [31:0] w;
    check("out_valid", 32'(out_valid), 32'(q_instr.size() != 0));
    check("in_ready", 32'(in_ready), 32'(q_instr.size() < 2));
    if (q_instr.size() != 0) begin
      w = q_instr[0];
      check("out_instr", out_instr, w);
      check("out_pc", out_pc, q_pc[0]);
      check("shamt", 32'(iimm_shamt), (w >> 20) % 32);
      check("iimm", 32'(iimm), w >> 20);
      check("simm", 32'(simm), ((w >> 25) * 32) + ((w >> 7) % 32));
      check("bimm", 32'(bimm), ref_bimm(w));
      check("uimm", 32'(uimm), UJ ? (w >> 12) : 32'd0);
      check("jimm", 32'(jimm), ref_jimm(w));
      check("ext_op", 32'(ext_op), 32'(ref_ext(w)));
      check("illegal", 32'(illegal), 32'(ref_illegal(w)));
    end
  endtask

  // One clock: drive at negedge, update model at posedge, compare at next negedge.
  task automatic step(input logic v, input logic [31:0] instr, input logic rdy, input logic fl);
    logic acc, del;
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc_ctr;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    acc = v && (q_instr.size() < 2);
    del = rdy && (q_instr.size() != 0);
    if (fl || rst) begin
      q_instr.delete();
      q_pc.delete();
    end else begin
      if (del) begin
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end
      if (acc) begin
        q_instr.push_back(instr);
        q_pc.push_back(pc_ctr);
      end
    end
    pc_ctr = pc_ctr + 4;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    compare_all();
  endtask

  logic [6:0] ops[13] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                          7'h6F, 7'h33, 7'h0F, 7'h73, 7'h7F, 7'h2B};

  initial begin
    logic [31:0] w;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_instr", out_instr, 0);
    check("rst_iimm", 32'(iimm), 0);
    check("rst_ext_op", 32'(ext_op), 0);
    check("rst_illegal", 32'(illegal), 0);

    step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    check("addi_iimm", 32'(iimm), 32'hFFF);
    check("addi_ext", 32'(ext_op), 2);
    check("addi_ill", 32'(illegal), 0);

    step(1'b1, 32'h00509093, 1'b1, 1'b0);
    check("slli_shamt", 32'(iimm_shamt), 5);
    check("slli_ext", 32'(ext_op), 3);
    step(1'b1, 32'h0020A423, 1'b1, 1'b0);
    check("sw_simm", 32'(simm), 32'h008);
    check("sw_ext", 32'(ext_op), 1);
    step(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
    check("beq_bimm", 32'(bimm), 32'hFFE);
    check("beq_ext", 32'(ext_op), 4);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'h00100093, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 1'b0, 1'b0);
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_iimm0", 32'(iimm), 1);
    step(1'b1, 32'h00300093, 1'b0, 1'b0);
    check("bp_hold_iimm", 32'(iimm), 1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_second", 32'(iimm), 2);
    check("bp_ready_again", 32'(in_ready), 1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_drained", 32'(out_valid), 0);

    step(1'b1, 32'h00400093, 1'b0, 1'b0);
    step(1'b1, 32'h00500093, 1'b0, 1'b0);
    step(1'b1, 32'h00600093, 1'b1, 1'b1);
    check("flush_valid", 32'(out_valid), 0);
    check("flush_ready", 32'(in_ready), 1);
    step(1'b1, 32'h00700093, 1'b0, 1'b0);
    step(1'b1, 32'h00800093, 1'b1, 1'b1);
    check("flush_one_valid", 32'(out_valid), 0);
    step(1'b1, 32'h00900093, 1'b1, 1'b0);
    check("post_flush_iimm", 32'(iimm), 9);

    step(1'b1, 32'h123450B7, 1'b1, 1'b0);
    check("lui_uimm", 32'(uimm), UJ ? 32'h12345 : 32'h0);
    check("lui_ext", 32'(ext_op), UJ ? 5 : 0);
    step(1'b1, 32'h0000007F, 1'b1, 1'b0);
    check("bad_illegal", 32'(illegal), 1);
    check("bad_ext", 32'(ext_op), 0);

    step(1'b1, 32'h00A00093, 1'b0, 1'b0);
    step(1'b1, 32'h00B00093, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 32'h00C00093, 1'b1, 1'b0);
    rst = 1'b0;
    check("rst_stall_instr", out_instr, 0);
    check("rst_stall_iimm", 32'(iimm), 0);

    for (int i = 0; i < 400; i++) begin
      w = $urandom();
      w[6:0] = ops[$urandom_range(0, 12)];
      step(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
